// File: rtl/dcache_port_arbiter_if.sv
// Data-cache port bundle: load-stage, store-stage and cache-side signals,
// plus arbiter status. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the pipeline and cache sides.
interface dcache_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  // Handshakes: a *_reqcyc request stays asserted until its *_reqack is seen
  // high in the same cycle; a response beat transfers on a cycle where both
  // *_respcyc and *_respack are high; writeack is a single-cycle completion
  // pulse with no back-pressure.
  logic              rd_reqcyc;
  logic [ADDR_W-1:0] rd_req;
  logic [TAG_W-1:0]  rd_reqtag;
  logic              rd_reqack;
  logic              rd_respcyc;
  logic [DATA_W-1:0] rd_resp;
  logic [TAG_W-1:0]  rd_resptag;
  logic              rd_respack;

  logic              wr_reqcyc;
  logic [ADDR_W-1:0] wr_req;
  logic [DATA_W-1:0] wr_reqdata;
  logic [TAG_W-1:0]  wr_reqtag;
  logic              wr_reqack;
  logic              wr_writeack;

  logic              mem_reqcyc;
  logic [ADDR_W-1:0] mem_req;
  logic [DATA_W-1:0] mem_reqdata;
  logic [TAG_W-1:0]  mem_reqtag;
  logic              mem_reqack;
  logic              mem_respcyc;
  logic [DATA_W-1:0] mem_resp;
  logic [TAG_W-1:0]  mem_resptag;
  logic              mem_respack;
  logic              mem_writeack;

  logic              grant_wr;
  logic              busy;
  logic              protocol_err;

  modport slave (
    input  rd_reqcyc, rd_req, rd_reqtag, rd_respack,
    input  wr_reqcyc, wr_req, wr_reqdata, wr_reqtag,
    input  mem_reqack, mem_respcyc, mem_resp, mem_resptag, mem_writeack,
    output rd_reqack, rd_respcyc, rd_resp, rd_resptag,
    output wr_reqack, wr_writeack,
    output mem_reqcyc, mem_req, mem_reqdata, mem_reqtag, mem_respack,
    output grant_wr, busy, protocol_err
  );

  modport master (
    output rd_reqcyc, rd_req, rd_reqtag, rd_respack,
    output wr_reqcyc, wr_req, wr_reqdata, wr_reqtag,
    output mem_reqack, mem_respcyc, mem_resp, mem_resptag, mem_writeack,
    input  rd_reqack, rd_respcyc, rd_resp, rd_resptag,
    input  wr_reqack, wr_writeack,
    input  mem_reqcyc, mem_req, mem_reqdata, mem_reqtag, mem_respack,
    input  grant_wr, busy, protocol_err
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Arbiter sharing one data-cache request/response bus between the load path
// (RD) and the store path (WR). One owner at a time; the grant is held until
// the final read beat is consumed or the write is acknowledged. Ties in IDLE
// go to the requester that did not own the bus last.
module dcache_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 13,
  parameter int RD_BEATS = 8,
  localparam int CNT_W   = (RD_BEATS > 1) ? $clog2(RD_BEATS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  dcache_port_arbiter_if.slave bus,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RD_BEATS - 1);

  state_t            state_q, state_d;
  logic              mem_reqcyc_q, mem_reqcyc_d;
  logic [ADDR_W-1:0] mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_reqdata_q, mem_reqdata_d;
  logic [TAG_W-1:0]  mem_reqtag_q, mem_reqtag_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              last_owner_q, last_owner_d;   // 1 = WR owned last
  logic              protocol_err_q, protocol_err_d;

  logic              pick_wr;
  logic              beat_xfer;
  logic              wr_fast_done;
  logic              writeack_ok;

  // Combinational outputs
  logic              rd_reqack_c;
  logic              rd_respcyc_c;
  logic [DATA_W-1:0] rd_resp_c;
  logic [TAG_W-1:0]  rd_resptag_c;
  logic              wr_reqack_c;
  logic              wr_writeack_c;
  logic              mem_respack_c;

  // WR wins when it is the only requester, or on a tie when RD owned last.
  assign pick_wr      = bus.wr_reqcyc && (!bus.rd_reqcyc || !last_owner_q);
  assign beat_xfer    = (state_q == S_RD_WAIT) && bus.mem_respcyc && bus.rd_respack;
  // Write acked and completed in the same cycle.
  assign wr_fast_done = (state_q == S_WR_REQ) && bus.mem_reqack && bus.mem_writeack;
  assign writeack_ok  = (state_q == S_WR_WAIT) || wr_fast_done;

  // State and captured-request registers; reset drops the bus request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      mem_reqcyc_q   <= 1'b0;
      mem_req_q      <= '0;
      mem_reqdata_q  <= '0;
      mem_reqtag_q   <= '0;
      beat_cnt_q     <= '0;
      last_owner_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_reqcyc_q   <= mem_reqcyc_d;
      mem_req_q      <= mem_req_d;
      mem_reqdata_q  <= mem_reqdata_d;
      mem_reqtag_q   <= mem_reqtag_d;
      beat_cnt_q     <= beat_cnt_d;
      last_owner_q   <= last_owner_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Next-state: arbitration, request capture, beat counting, stray detection.
  always_comb begin
    state_d        = state_q;
    mem_reqcyc_d   = mem_reqcyc_q;
    mem_req_d      = mem_req_q;
    mem_reqdata_d  = mem_reqdata_q;
    mem_reqtag_d   = mem_reqtag_q;
    beat_cnt_d     = beat_cnt_q;
    last_owner_d   = last_owner_q;
    protocol_err_d = protocol_err_q;

    case (state_q)
      S_IDLE: begin
        if (pick_wr) begin
          state_d       = S_WR_REQ;
          mem_reqcyc_d  = 1'b1;
          mem_req_d     = bus.wr_req;
          mem_reqdata_d = bus.wr_reqdata;
          mem_reqtag_d  = bus.wr_reqtag;
          last_owner_d  = 1'b1;
        end else if (bus.rd_reqcyc) begin
          state_d       = S_RD_REQ;
          mem_reqcyc_d  = 1'b1;
          mem_req_d     = bus.rd_req;
          mem_reqdata_d = '0;
          mem_reqtag_d  = bus.rd_reqtag;
          last_owner_d  = 1'b0;
        end
      end
      S_RD_REQ: begin
        if (bus.mem_reqack) begin
          mem_reqcyc_d = 1'b0;
          state_d      = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (beat_xfer) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        if (bus.mem_reqack) begin
          mem_reqcyc_d = 1'b0;
          state_d      = bus.mem_writeack ? S_IDLE : S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (bus.mem_writeack) state_d = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        mem_reqcyc_d = 1'b0;
      end
    endcase

    if (bus.mem_respcyc && (state_q != S_RD_WAIT)) protocol_err_d = 1'b1;
    if (bus.mem_writeack && !writeack_ok)          protocol_err_d = 1'b1;
  end

  // Outputs: owner-gated acks and the read-response pass-through.
  always_comb begin
    rd_reqack_c   = 1'b0;
    rd_respcyc_c  = 1'b0;
    rd_resp_c     = '0;
    rd_resptag_c  = '0;
    wr_reqack_c   = 1'b0;
    wr_writeack_c = 1'b0;
    mem_respack_c = 1'b0;
    case (state_q)
      S_RD_REQ:  rd_reqack_c = bus.mem_reqack;
      S_RD_WAIT: begin
        rd_respcyc_c  = bus.mem_respcyc;
        rd_resp_c     = bus.mem_resp;
        rd_resptag_c  = bus.mem_resptag;
        mem_respack_c = bus.rd_respack;
      end
      S_WR_REQ: begin
        wr_reqack_c   = bus.mem_reqack;
        wr_writeack_c = wr_fast_done;
      end
      S_WR_WAIT: wr_writeack_c = bus.mem_writeack;
      default: ;
    endcase
  end

  assign bus.rd_reqack    = rd_reqack_c;
  assign bus.rd_respcyc   = rd_respcyc_c;
  assign bus.rd_resp      = rd_resp_c;
  assign bus.rd_resptag   = rd_resptag_c;
  assign bus.wr_reqack    = wr_reqack_c;
  assign bus.wr_writeack  = wr_writeack_c;
  assign bus.mem_reqcyc   = mem_reqcyc_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_reqdata  = mem_reqdata_q;
  assign bus.mem_reqtag   = mem_reqtag_q;
  assign bus.mem_respack  = mem_respack_c;
  assign bus.grant_wr     = last_owner_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.protocol_err = protocol_err_q;

  assign state_o    = state_q;
  assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;
  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int TAG_W    = 13;
  localparam int RD_BEATS = 8;
  localparam int CNT_W    = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  logic [2:0]       state_o;
  logic [CNT_W-1:0] beat_cnt_o;

  dcache_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .RD_BEATS(RD_BEATS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_o(state_o),
    .beat_cnt_o(beat_cnt_o)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0]      exp_q[$];   // expected read beats
  logic [TAG_W-1:0] grant_q[$]; // expected grant order, by tag

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_reqcyc    = 1'b0;
    bus.rd_req       = '0;
    bus.rd_reqtag    = '0;
    bus.rd_respack   = 1'b0;
    bus.wr_reqcyc    = 1'b0;
    bus.wr_req       = '0;
    bus.wr_reqdata   = '0;
    bus.wr_reqtag    = '0;
    bus.mem_reqack   = 1'b0;
    bus.mem_respcyc  = 1'b0;
    bus.mem_resp     = '0;
    bus.mem_resptag  = '0;
    bus.mem_writeack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Deliver RD_BEATS beats; optionally stall beat 3 for two cycles.
  task automatic deliver_beats(input bit stall, input logic [63:0] base, input logic [TAG_W-1:0] tag);
    for (int i = 0; i < RD_BEATS; i++) begin
      bus.mem_respcyc = 1'b1;
      bus.mem_resp    = base + 64'(i);
      bus.mem_resptag = tag;
      exp_q.push_back(base + 64'(i));
      if (stall && i == 3) begin
        bus.rd_respack = 1'b0;
        for (int s = 0; s < 2; s++) begin
          settle();
          check_val("stall_respack", bus.mem_respack, 0);
          check_val("stall_respcyc", bus.rd_respcyc, 1);
          check_val("stall_beat_cnt", beat_cnt_o, 3);
          step();
        end
      end
      bus.rd_respack = 1'b1;
      settle();
      check_val("beat_respcyc", bus.rd_respcyc, 1);
      check_val("beat_busy", bus.busy, 1);
      check_val("beat_cnt", beat_cnt_o, i);
      check_val("beat_respack", bus.mem_respack, 1);
      check_val("beat_tag", bus.rd_resptag, tag);
      if (exp_q.size() > 0) check_val("beat_data", bus.rd_resp, exp_q.pop_front());
      else                  check_val("beat_queue_empty", 1, 0);
      step();
    end
    bus.mem_respcyc = 1'b0;
    bus.rd_respack  = 1'b0;
    settle();
    check_val("rd_done_state", state_o, ST_IDLE);
  endtask

  // Cache-side model: wait for a grant, check it against the expected order,
  // accept it, then complete it as a write or a read.
  task automatic serve_mem(input bit stall, input bit drop);
    int n = 0;
    logic [TAG_W-1:0] exp_tag;
    bit is_wr;
    while (!bus.mem_reqcyc && n < 50) begin
      step();
      n++;
    end
    if (!bus.mem_reqcyc) begin
      check_val("grant_timeout", 0, 1);
      return;
    end
    if (grant_q.size() == 0) begin
      check_val("grant_unexpected", 1, 0);
      return;
    end
    exp_tag = grant_q.pop_front();
    is_wr   = exp_tag[TAG_W-1];
    check_val("grant_tag", bus.mem_reqtag, exp_tag);
    check_val("grant_wr", bus.grant_wr, is_wr);
    bus.mem_reqack = 1'b1;
    settle();
    check_val("owner_reqack", is_wr ? bus.wr_reqack : bus.rd_reqack, 1);
    check_val("other_reqack", is_wr ? bus.rd_reqack : bus.wr_reqack, 0);
    step();
    bus.mem_reqack = 1'b0;
    if (drop) begin
      if (is_wr) bus.wr_reqcyc = 1'b0;
      else       bus.rd_reqcyc = 1'b0;
    end
    if (is_wr) begin
      step();
      bus.mem_writeack = 1'b1;
      settle();
      check_val("wr_writeack", bus.wr_writeack, 1);
      step();
      bus.mem_writeack = 1'b0;
      settle();
      check_val("wr_done_busy", bus.busy, 0);
    end else begin
      deliver_beats(stall, {48'h0, exp_tag, 3'b000}, exp_tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    check_val("rst_mem_reqcyc", bus.mem_reqcyc, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_state", state_o, ST_IDLE);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    check_val("idle_mem_reqcyc", bus.mem_reqcyc, 0);
    check_val("idle_mem_req", bus.mem_req, 0);
    check_val("idle_mem_reqtag", bus.mem_reqtag, 0);
    check_val("idle_grant_wr", bus.grant_wr, 0);
    check_val("idle_busy", bus.busy, 0);
    check_val("idle_protocol_err", bus.protocol_err, 0);
    check_val("idle_rd_respcyc", bus.rd_respcyc, 0);
    check_val("idle_wr_writeack", bus.wr_writeack, 0);

    // WR alone, cycle-accurate
    bus.wr_reqcyc  = 1'b1;                 // cycle 0
    bus.wr_req     = 64'h1000;
    bus.wr_reqdata = 64'hDEADBEEF;
    bus.wr_reqtag  = 13'h1000;
    settle();
    check_val("wr_c0_mem_reqcyc", bus.mem_reqcyc, 0);
    step();                                // cycle 1
    check_val("wr_c1_mem_reqcyc", bus.mem_reqcyc, 1);
    check_val("wr_c1_mem_req", bus.mem_req, 64'h1000);
    check_val("wr_c1_mem_reqdata", bus.mem_reqdata, 64'hDEADBEEF);
    check_val("wr_c1_mem_reqtag", bus.mem_reqtag, 13'h1000);
    check_val("wr_c1_grant_wr", bus.grant_wr, 1);
    check_val("wr_c1_state", state_o, ST_WR_REQ);
    step();                                // cycle 2
    step();                                // cycle 3
    bus.mem_reqack = 1'b1;
    settle();
    check_val("wr_c3_wr_reqack", bus.wr_reqack, 1);
    step();                                // cycle 4
    bus.mem_reqack = 1'b0;
    bus.wr_reqcyc  = 1'b0;
    settle();
    check_val("wr_c4_mem_reqcyc", bus.mem_reqcyc, 0);
    check_val("wr_c4_state", state_o, ST_WR_WAIT);
    check_val("wr_c4_wr_reqack", bus.wr_reqack, 0);
    step();                                // cycle 5
    step();                                // cycle 6
    bus.mem_writeack = 1'b1;
    settle();
    check_val("wr_c6_wr_writeack", bus.wr_writeack, 1);
    step();                                // cycle 7
    bus.mem_writeack = 1'b0;
    settle();
    check_val("wr_c7_busy", bus.busy, 0);
    check_val("wr_c7_protocol_err", bus.protocol_err, 0);

    // Round-robin: both held continuously, grants alternate starting with WR
    do_reset();
    bus.rd_reqcyc  = 1'b1;
    bus.rd_req     = 64'h2000;
    bus.rd_reqtag  = 13'h0123;
    bus.wr_reqcyc  = 1'b1;
    bus.wr_req     = 64'h3000;
    bus.wr_reqdata = 64'h55;
    bus.wr_reqtag  = 13'h1456;
    grant_q.push_back(13'h1456);
    grant_q.push_back(13'h0123);
    grant_q.push_back(13'h1456);
    grant_q.push_back(13'h0123);
    for (int g = 0; g < 4; g++) serve_mem(1'b0, 1'b0);
    bus.rd_reqcyc = 1'b0;
    bus.wr_reqcyc = 1'b0;
    step();
    check_val("rr_end_mem_reqcyc", bus.mem_reqcyc, 0);
    check_val("rr_end_busy", bus.busy, 0);

    // Read with a two-cycle stall on beat 3
    do_reset();
    bus.rd_reqcyc = 1'b1;
    bus.rd_req    = 64'h4000;
    bus.rd_reqtag = 13'h0042;
    grant_q.push_back(13'h0042);
    serve_mem(1'b1, 1'b1);
    step();
    check_val("stall_end_busy", bus.busy, 0);
    check_val("stall_end_err", bus.protocol_err, 0);

    // Stray response beat while idle
    do_reset();
    bus.mem_respcyc = 1'b1;
    bus.rd_respack  = 1'b1;
    settle();
    check_val("stray_resp_respack", bus.mem_respack, 0);
    check_val("stray_resp_rd_respcyc", bus.rd_respcyc, 0);
    step();
    bus.mem_respcyc = 1'b0;
    bus.rd_respack  = 1'b0;
    settle();
    check_val("stray_resp_err", bus.protocol_err, 1);
    repeat (3) step();
    check_val("stray_resp_err_sticky", bus.protocol_err, 1);

    // Stray writeack during RD_WAIT, then reset in the middle of RD_WAIT
    do_reset();
    bus.rd_reqcyc = 1'b1;
    bus.rd_req    = 64'h5000;
    bus.rd_reqtag = 13'h0055;
    step();
    bus.mem_reqack = 1'b1;
    step();
    bus.mem_reqack = 1'b0;
    bus.rd_reqcyc  = 1'b0;
    settle();
    check_val("rdwait_state", state_o, ST_RD_WAIT);
    bus.mem_writeack = 1'b1;
    settle();
    check_val("stray_wack_wr_writeack", bus.wr_writeack, 0);
    step();
    bus.mem_writeack = 1'b0;
    settle();
    check_val("stray_wack_err", bus.protocol_err, 1);
    check_val("stray_wack_state", state_o, ST_RD_WAIT);
    reset = 1'b1;
    #1;
    check_val("rst_rdwait_busy", bus.busy, 0);
    check_val("rst_rdwait_state", state_o, ST_IDLE);
    check_val("rst_rdwait_err", bus.protocol_err, 0);
    step();
    reset = 1'b0;
    step();

    // Reset while the request is on the bus
    bus.rd_reqcyc = 1'b1;
    bus.rd_req    = 64'h6000;
    bus.rd_reqtag = 13'h0066;
    step();
    settle();
    check_val("rdreq_mem_reqcyc", bus.mem_reqcyc, 1);
    check_val("rdreq_state", state_o, ST_RD_REQ);
    reset = 1'b1;
    #1;
    check_val("rst_rdreq_mem_reqcyc", bus.mem_reqcyc, 0);
    check_val("rst_rdreq_busy", bus.busy, 0);
    bus.rd_reqcyc = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Write accepted and completed in the same cycle
    bus.wr_reqcyc  = 1'b1;
    bus.wr_req     = 64'h7000;
    bus.wr_reqdata = 64'h77;
    bus.wr_reqtag  = 13'h1777;
    step();
    check_val("fast_state", state_o, ST_WR_REQ);
    bus.mem_reqack   = 1'b1;
    bus.mem_writeack = 1'b1;
    settle();
    check_val("fast_wr_reqack", bus.wr_reqack, 1);
    check_val("fast_wr_writeack", bus.wr_writeack, 1);
    step();
    bus.mem_reqack   = 1'b0;
    bus.mem_writeack = 1'b0;
    bus.wr_reqcyc    = 1'b0;
    settle();
    check_val("fast_next_state", state_o, ST_IDLE);
    check_val("fast_next_busy", bus.busy, 0);
    check_val("fast_no_err", bus.protocol_err, 0);
    check_val("leftover_grants", grant_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
